// File: rtl/cpuConfig.sv
// Shared configuration for the picoMIPS core and its board-facing input stage.
package cpuConfig;
  localparam int N         = 8;
  localparam int SW_WIDTH  = 10;
  localparam int HS_BIT    = 8;
  localparam int DB_CYCLES = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hsState_t;
endpackage

// File: rtl/switch_debounce.sv
// Single-bit two-flop synchroniser followed by a consecutive-sample debouncer.
// rise flags the first cycle in which the debounced level reads high.
module switch_debounce #(
  parameter int DB_CYCLES = 16,
  parameter int DB_CNT_W  = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise
);
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                db_q, db_prev_q;
  logic [DB_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= in;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      // Any sample that agrees with the debounced level restarts the run.
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out  = db_q;
  assign rise = db_q & ~db_prev_q;
endmodule

// File: rtl/switch_conditioner.sv
// Board switch input stage: synchronises all lines, debounces the handshake
// switch and captures the data switches with a valid/consume handshake.
//   state | meaning
//   EMPTY | no unconsumed capture, dataValid=0
//   FULL  | dataOut holds a capture the core has not consumed, dataValid=1
module switch_conditioner
  import cpuConfig::*;
#(
  parameter int N         = cpuConfig::N,
  parameter int SW_WIDTH  = cpuConfig::SW_WIDTH,
  parameter int HS_BIT    = cpuConfig::HS_BIT,
  parameter int DB_CYCLES = cpuConfig::DB_CYCLES,
  parameter int DB_CNT_W  = $clog2(DB_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switchesRaw,
  output logic [SW_WIDTH-1:0] switchesOut,
  output logic [N-1:0]        dataOut,
  output logic                dataValid,
  input  logic                dataConsume,
  output logic                pressStrobe,
  output logic                overrun
);
  logic [SW_WIDTH-1:0] sw_sync;
  logic                hs_db, hs_rise;
  hsState_t            state_q;
  logic [N-1:0]        data_q;
  logic                strobe_q, overrun_q;

  switch_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .DB_CNT_W (DB_CNT_W)
  ) u_hs_debounce (
    .clk  (clk),
    .reset(reset),
    .in   (switchesRaw[HS_BIT]),
    .out  (hs_db),
    .rise (hs_rise)
  );

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    if (i == HS_BIT) begin : g_hs
      assign sw_sync[i] = hs_db;
    end else begin : g_sync
      logic s1_q, s2_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else begin
          s1_q <= switchesRaw[i];
          s2_q <= s1_q;
        end
      end
      assign sw_sync[i] = s2_q;
    end
  end

  // Capture uses the synced data present in the cycle the debounced level rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      strobe_q <= hs_rise;
      case (state_q)
        EMPTY: begin
          if (hs_rise) begin
            data_q  <= sw_sync[N-1:0];
            state_q <= FULL;
          end
        end
        FULL: begin
          if (hs_rise && dataConsume) begin
            data_q <= sw_sync[N-1:0];
          end else if (hs_rise) begin
            overrun_q <= 1'b1;
          end else if (dataConsume) begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign switchesOut = sw_sync;
  assign dataOut     = data_q;
  assign dataValid   = (state_q == FULL);
  assign pressStrobe = strobe_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner against a cycle-level behavioural model.
module tb_switch_conditioner;
  import cpuConfig::*;

  localparam int W  = SW_WIDTH;
  localparam int VW = W + N + 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] switchesRaw = '0;
  logic         dataConsume = 1'b0;
  logic [W-1:0] switchesOut;
  logic [N-1:0] dataOut;
  logic         dataValid, pressStrobe, overrun;

  int checks = 0;
  int failures = 0;

  switch_conditioner dut (
    .clk        (clk),
    .reset      (reset),
    .switchesRaw(switchesRaw),
    .switchesOut(switchesOut),
    .dataOut    (dataOut),
    .dataValid  (dataValid),
    .dataConsume(dataConsume),
    .pressStrobe(pressStrobe),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Model state: raw samples delayed by two cycles, debounced level as a
  // run length of disagreeing samples, and the capture/overrun bookkeeping.
  logic [W-1:0] m_s1, m_s2, m_sw;
  logic         m_db, m_rose, m_valid, m_strobe, m_ovr;
  logic [N-1:0] m_data;
  int           m_run;

  logic [VW-1:0] dut_vec, mdl_vec;
  assign dut_vec = {switchesOut, dataOut, dataValid, pressStrobe, overrun};
  assign mdl_vec = {m_sw, m_data, m_valid, m_strobe, m_ovr};

  task automatic model_update();
    logic press;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = 1'b0; m_rose = 1'b0; m_run = 0;
      m_valid = 1'b0; m_strobe = 1'b0; m_ovr = 1'b0; m_data = '0;
    end else begin
      press = m_rose;
      if (press) begin
        if (!m_valid) begin
          m_data = m_s2[N-1:0];
          m_valid = 1'b1;
        end else if (dataConsume) begin
          m_data = m_s2[N-1:0];
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && dataConsume) begin
        m_valid = 1'b0;
      end
      m_strobe = press;
      m_rose = 1'b0;
      if (m_s2[HS_BIT] != m_db) begin
        m_run++;
        if (m_run == DB_CYCLES) begin
          m_db = ~m_db;
          m_run = 0;
          m_rose = m_db;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = switchesRaw;
    end
    m_sw = m_s2;
    m_sw[HS_BIT] = m_db;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] mk(input logic hs, input logic [N-1:0] d);
    logic [W-1:0] r;
    r = '0;
    r[N-1:0] = d;
    r[HS_BIT] = hs;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; switchesRaw = '0; dataConsume = 1'b0;
    tick(); tick();
    if (dut_vec !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", dut_vec); end
    checks++;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (dut_vec !== '0) begin failures++; $display("FAIL idle_zero cyc=%0d got=%h exp=0", c, dut_vec); end
      checks++;
    end
    switchesRaw = 10'h0A5;
    tick();
    if (switchesOut !== 10'h000) begin failures++; $display("FAIL sync_lat1 got=%h exp=000", switchesOut); end
    checks++;
    tick();
    if (switchesOut !== 10'h0A5) begin failures++; $display("FAIL sync_lat2 got=%h exp=0a5", switchesOut); end
    checks++;
    for (int c = 0; c < 4; c++) begin
      if (pressStrobe !== 1'b0 || dut_vec !== mdl_vec) begin
        failures++; $display("FAIL sync_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_press();
    int first, cnt;
    first = -1; cnt = 0;
    switchesRaw = mk(1'b1, 8'h3C);
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (pressStrobe === 1'b1) begin cnt++; if (first < 0) first = c; end
      if (dut_vec !== mdl_vec) begin failures++; $display("FAIL press_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec); end
      checks++;
    end
    if (first != 2 + DB_CYCLES + 1 || cnt != 1) begin
      failures++; $display("FAIL press_timing got_cyc=%0d got_cnt=%0d exp_cyc=%0d exp_cnt=1", first, cnt, 2 + DB_CYCLES + 1);
    end
    checks++;
    if (dataOut !== 8'h3C || dataValid !== 1'b1) begin
      failures++; $display("FAIL press_capture got=%h/%b exp=3c/1", dataOut, dataValid);
    end
    checks++;
    dataConsume = 1'b1;
    tick();
    dataConsume = 1'b0;
    if (dataValid !== 1'b0 || dataOut !== 8'h3C) begin
      failures++; $display("FAIL consume got=%h/%b exp=3c/0", dataOut, dataValid);
    end
    checks++;
    switchesRaw = mk(1'b0, 8'h3C);
    for (int c = 0; c < 22; c++) begin
      tick();
      if (pressStrobe !== 1'b0 || dut_vec !== mdl_vec) begin
        failures++; $display("FAIL release_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec);
      end
      checks++;
    end
  endtask

  task automatic test_bounce();
    int cnt, first;
    cnt = 0; first = -1;
    for (int k = 0; k < 8; k++) begin
      switchesRaw = mk(~k[0], N'($urandom));
      for (int c = 0; c < 5; c++) begin
        tick();
        if (pressStrobe === 1'b1) cnt++;
        if (dut_vec !== mdl_vec) begin failures++; $display("FAIL bounce_model k=%0d got=%h exp=%h", k, dut_vec, mdl_vec); end
        checks++;
      end
    end
    switchesRaw = mk(1'b1, 8'h5A);
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (pressStrobe === 1'b1) begin cnt++; if (first < 0) first = c; end
      if (dut_vec !== mdl_vec) begin failures++; $display("FAIL settle_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec); end
      checks++;
    end
    if (cnt != 1 || first != 2 + DB_CYCLES + 1 || dataOut !== 8'h5A) begin
      failures++; $display("FAIL bounce_press got_cnt=%0d got_cyc=%0d data=%h exp_cnt=1 exp_cyc=%0d data=5a", cnt, first, dataOut, 2 + DB_CYCLES + 1);
    end
    checks++;
    dataConsume = 1'b1; tick(); dataConsume = 1'b0;
    switchesRaw = mk(1'b0, 8'h5A);
    for (int c = 0; c < 22; c++) tick();
  endtask

  task automatic test_overrun();
    switchesRaw = mk(1'b1, 8'h11);
    for (int c = 0; c < 22; c++) tick();
    switchesRaw = mk(1'b0, 8'h11);
    for (int c = 0; c < 22; c++) tick();
    switchesRaw = mk(1'b1, 8'h22);
    for (int c = 0; c < 22; c++) begin
      tick();
      if (dut_vec !== mdl_vec) begin failures++; $display("FAIL ovr_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec); end
      checks++;
    end
    if (dataOut !== 8'h11 || overrun !== 1'b1 || dataValid !== 1'b1) begin
      failures++; $display("FAIL overrun_set got=%h/%b/%b exp=11/1/1", dataOut, overrun, dataValid);
    end
    checks++;
    switchesRaw = mk(1'b0, 8'h22);
    for (int c = 0; c < 22; c++) tick();
    dataConsume = 1'b1; tick(); dataConsume = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    if (dataValid !== 1'b0 || overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_sticky got=%b/%b exp=0/1", dataValid, overrun);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    reset = 1'b1; tick(); reset = 1'b0;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_reset got=%b exp=0", overrun); end
    checks++;
    switchesRaw = mk(1'b1, 8'h11);
    for (int c = 0; c < 22; c++) tick();
    switchesRaw = mk(1'b0, 8'h11);
    for (int c = 0; c < 22; c++) tick();
    switchesRaw = mk(1'b1, 8'h22);
    for (int c = 0; c < 2 + DB_CYCLES; c++) tick();
    dataConsume = 1'b1;
    tick();
    dataConsume = 1'b0;
    if (pressStrobe !== 1'b1 || dataOut !== 8'h22 || dataValid !== 1'b1 || overrun !== 1'b0) begin
      failures++; $display("FAIL b2b_consume got=%b/%h/%b/%b exp=1/22/1/0", pressStrobe, dataOut, dataValid, overrun);
    end
    checks++;
    if (dut_vec !== mdl_vec) begin failures++; $display("FAIL b2b_model got=%h exp=%h", dut_vec, mdl_vec); end
    checks++;
    dataConsume = 1'b1; tick(); dataConsume = 1'b0;
    switchesRaw = mk(1'b0, 8'h22);
    for (int c = 0; c < 22; c++) tick();
  endtask

  task automatic test_reset_mid();
    int first, cnt;
    first = -1; cnt = 0;
    switchesRaw = mk(1'b1, 8'h77);
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    if (dut_vec !== '0) begin failures++; $display("FAIL midreset_zero got=%h exp=0", dut_vec); end
    checks++;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (pressStrobe === 1'b1) begin cnt++; if (first < 0) first = c; end
      if (dut_vec !== mdl_vec) begin failures++; $display("FAIL powerup_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec); end
      checks++;
    end
    if (cnt != 1 || first != 2 + DB_CYCLES + 1 || dataOut !== 8'h77) begin
      failures++; $display("FAIL powerup_press got_cnt=%0d got_cyc=%0d data=%h exp_cnt=1 exp_cyc=%0d data=77", cnt, first, dataOut, 2 + DB_CYCLES + 1);
    end
    checks++;
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int p = 0; p < 8; p++) begin
      switchesRaw = mk(1'b1, N'($urandom));
      switchesRaw[W-1] = 1'($urandom);
      for (int c = 0; c < int'($urandom_range(17, 26)); c++) begin
        dataConsume = ($urandom_range(0, 3) == 0);
        tick();
        if (dut_vec !== mdl_vec) begin failures++; $display("FAIL rand_hold p=%0d c=%0d got=%h exp=%h", p, c, dut_vec, mdl_vec); end
        checks++;
      end
      switchesRaw[HS_BIT] = 1'b0;
      for (int c = 0; c < int'($urandom_range(20, 26)); c++) begin
        dataConsume = ($urandom_range(0, 3) == 0);
        tick();
        if (dut_vec !== mdl_vec) begin failures++; $display("FAIL rand_rel p=%0d c=%0d got=%h exp=%h", p, c, dut_vec, mdl_vec); end
        checks++;
      end
    end
    dataConsume = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input stage between the board switches and the picoMIPS core. Feeds the core's switch input, which the core reads for immediate operands and as a demo input.
- Synchronises all switch lines to clk and debounces one handshake switch.
- On each debounced press of the handshake switch, captures the data switches into a holding register and presents them with a valid/consume handshake. Detects presses the core has not yet consumed (overrun).

Parameters:
- N, 8, data width captured from SW[N-1:0]; equals cpuConfig::N
- SW_WIDTH, 10, number of board switch lines
- HS_BIT, 8, index of the handshake switch; must be >= N and < SW_WIDTH
- DB_CYCLES, 16, consecutive differing synced samples needed to flip the debounced state; must be >= 2
- DB_CNT_W, $clog2(DB_CYCLES), debounce counter width

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- switchesRaw  in  SW_WIDTH  asynchronous board switches (SW)
- switchesOut  out  SW_WIDTH  synchronised switches; bit HS_BIT is replaced by the debounced value; drives the core's switchesIn
- dataOut  out  N  data captured at the last accepted press
- dataValid  out  1  dataOut holds an unconsumed capture
- dataConsume  in  1  core acknowledges dataOut; single-cycle pulse or level
- pressStrobe  out  1  one-cycle pulse on a debounced rising edge of the handshake switch
- overrun  out  1  sticky flag: a press arrived while dataValid=1 and was not consumed that cycle

Behaviour:
- Reset
  - Synchronous. The cycle after reset is sampled high, every flop is 0: sync stages, debounced state, counter, dataOut, dataValid, pressStrobe, overrun.
  - A reset mid-debounce or mid-handshake discards all state.
- Synchroniser
  - Two flops per bit, sync1 -> sync2.
  - switchesOut[i] = sync2[i] for i != HS_BIT. A raw change appears on switchesOut 2 cycles later.
- Debounce (HS_BIT only)
  - Holds state db and counter cnt.
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Effect: db flips on the DB_CYCLES-th consecutive cycle in which sync2 != db. Any glitch back to equal restarts the count.
  - switchesOut[HS_BIT] = db.
- Press
  - pressStrobe = 1 for exactly the one cycle after db goes 0->1 (registered edge detect). A 1->0 transition produces nothing.
- Handshake FSM, states EMPTY (dataValid=0) and FULL (dataValid=1), registered:
  - EMPTY, press: dataOut <= sync2[N-1:0] sampled in the cycle db rises; go to FULL.
  - EMPTY, dataConsume: ignored.
  - FULL, dataConsume with no press: go to EMPTY. dataValid falls the next cycle; dataOut is retained.
  - FULL, press with no dataConsume: dataOut is not overwritten (first capture wins); overrun <= 1; stay FULL.
  - FULL, press and dataConsume in the same cycle: dataOut <= new data; stay FULL; no overrun.
- overrun is cleared only by reset.
- Power-up with the handshake switch already high: db reaches 1 after 2+DB_CYCLES cycles and one press is generated. This is intended; the bench checks it.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Add SW_WIDTH, HS_BIT and DB_CYCLES defaults to package cpuConfig, next to N.
- Add hsState_t (EMPTY, FULL) enum to cpuConfig.
- One sub-module, switch_debounce: a single-bit synchroniser plus debouncer with parameter DB_CYCLES, ports clk, reset, in, out, rise.
- switch_conditioner instantiates one switch_debounce for HS_BIT and generates 2-flop synchronisers for the other bits.

Test Plan:
- Reset, then raw=10'h000 held -> all outputs 0; switchesRaw=10'h0A5 -> switchesOut=10'h0A5 exactly 2 cycles later, with no pressStrobe.
- Data 8'h3C, HS bit raised and held 20 cycles (DB_CYCLES=16) -> pressStrobe pulses once in cycle 2+16+1 after the rise; dataOut=8'h3C; dataValid=1; raising dataConsume for 1 cycle -> dataValid=0 the next cycle.
- HS bit bounces 0/1 every 5 cycles for 40 cycles, then settles high -> no pressStrobe until 16 stable cycles have elapsed, then exactly one.
- Capture 8'h11, no consume, second press with data 8'h22 -> dataOut stays 8'h11, overrun=1; a later consume clears dataValid but overrun stays 1 until reset.
- Capture 8'h11, second press with data 8'h22 timed so dataConsume is high in the press cycle -> dataOut=8'h22, dataValid stays 1, overrun=0.
- Press in progress (cnt about 8), reset pulsed for 1 cycle -> all outputs 0, cnt restarts; power-up with HS held high -> one press after 2+16 cycles.
